alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 130 +++++++++++++
 tb/tb_alu_exec_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - multi-cycle ALU execute stage with a bit-serial shifter
// Shifts take one cycle per bit; every other op completes in a single cycle.
module alu_exec_stage (
  input  logic        stage_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic        use_imm,
  input  logic [3:0]  alu_op,
  input  logic        wb_en,
  output logic [31:0] alu_out,
  output logic        save_to_reg,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  state_t      r_state;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic [3:0]  r_op;
  logic        r_wb;

  logic [31:0] w_opb;
  logic [4:0]  w_shamt;
  logic        w_is_shift;
  logic [31:0] w_result;
  logic [31:0] w_step;

  always_comb begin
    w_opb      = use_imm ? imm : rs2_data;
    w_shamt    = w_opb[4:0];
    w_is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
  end

  // Single-cycle result; shifts only land here when shamt is zero, so they pass A through.
  always_comb begin
    w_result = 32'd0;
    case (alu_op)
      OP_ADD:  w_result = rs1_data + w_opb;
      OP_SUB:  w_result = rs1_data - w_opb;
      OP_SLT:  w_result = ($signed(rs1_data) < $signed(w_opb)) ? 32'd1 : 32'd0;
      OP_SLTU: w_result = (rs1_data < w_opb) ? 32'd1 : 32'd0;
      OP_XOR:  w_result = rs1_data ^ w_opb;
      OP_OR:   w_result = rs1_data | w_opb;
      OP_AND:  w_result = rs1_data & w_opb;
      OP_SLL, OP_SRL, OP_SRA: w_result = rs1_data;
      default: w_result = 32'd0;
    endcase
  end

  always_comb begin
    w_step = r_work >> 1;
    case (r_op)
      OP_SLL:  w_step = r_work << 1;
      OP_SRA:  w_step = {r_work[31], r_work[31:1]};
      default: w_step = r_work >> 1;
    endcase
  end

  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_work      <= 32'd0;
      r_cnt       <= 5'd0;
      r_op        <= 4'd0;
      r_wb        <= 1'b0;
      alu_out     <= 32'd0;
      save_to_reg <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      save_to_reg <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op <= alu_op;
            r_wb <= wb_en;
            busy <= 1'b1;
            if (w_is_shift && (w_shamt != 5'd0)) begin
              r_work  <= rs1_data;
              r_cnt   <= w_shamt;
              r_state <= SHIFT;
            end else begin
              alu_out     <= w_result;
              done        <= 1'b1;
              save_to_reg <= wb_en;
              r_state     <= DONE;
            end
          end
        end
        SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - 5'd1;
          // The last shift and the move to DONE share an edge, giving shamt+1 cycle latency.
          if (r_cnt == 5'd1) begin
            alu_out     <= w_step;
            done        <= 1'b1;
            save_to_reg <= r_wb;
            r_state     <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - randomized self-checking bench for alu_exec_stage
// Expected results and latencies come from an arithmetic reference model.
module tb_alu_exec_stage;

  logic        stage_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        use_imm;
  logic [3:0]  alu_op;
  logic        wb_en;
  logic [31:0] alu_out;
  logic        save_to_reg;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  alu_exec_stage dut (
    .stage_clk  (stage_clk),
    .reset      (reset),
    .start      (start),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .imm        (imm),
    .use_imm    (use_imm),
    .alu_op     (alu_op),
    .wb_en      (wb_en),
    .alu_out    (alu_out),
    .save_to_reg(save_to_reg),
    .busy       (busy),
    .done       (done)
  );

  always #5 stage_clk = ~stage_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return $signed(a) >>> sh;
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'd2 || op == 4'd6 || op == 4'd7) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic tick();
    @(posedge stage_clk);
    #1;
  endtask

  // mode 1: second start with changed inputs during SHIFT; mode 2: start during DONE
  task automatic run_op(input logic [31:0] a, input logic [31:0] r2, input logic [31:0] im,
                        input logic ui, input logic [3:0] op, input logic wb, input int mode,
                        input string tag);
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
    int          n;
    b       = ui ? im : r2;
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op, b);
    rs1_data = a; rs2_data = r2; imm = im; use_imm = ui; alu_op = op; wb_en = wb;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 64) begin
      chk({tag, "_busy_inflight"}, 32'(busy), 32'd1);
      if (mode == 1 && n == 2) begin
        start = 1'b1; rs1_data = ~a; rs2_data = $urandom; imm = $urandom;
        use_imm = ~ui; alu_op = 4'd0; wb_en = ~wb;
      end
      if (mode == 1 && n == 3) start = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_alu_out"}, alu_out, exp_res);
    chk({tag, "_save"}, 32'(save_to_reg), 32'(wb));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    if (mode == 2) begin
      start = 1'b1; rs1_data = 32'h1111_1111; rs2_data = 32'h2222_2222;
      use_imm = 1'b0; alu_op = 4'd0; wb_en = 1'b1;
    end
    tick();
    start = 1'b0;
    chk({tag, "_done_after"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_save_after"}, 32'(save_to_reg), 32'd0);
    chk({tag, "_held"}, alu_out, exp_res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rs1_data = '0; rs2_data = '0; imm = '0;
    use_imm = 1'b0; alu_op = '0; wb_en = 1'b0;
    #1;
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_save", 32'(save_to_reg), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    run_op(32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 0, "add_ovf");
    chk("add_ovf_const", alu_out, 32'h8000_0000);
    run_op(32'h8000_0000, $urandom, 32'd4, 1'b1, 4'd7, 1'b0, 0, "sra4");
    chk("sra4_const", alu_out, 32'hF800_0000);
    run_op(32'h1234_5678, 32'd0, 32'd0, 1'b0, 4'd2, 1'b1, 0, "sll0");
    chk("sll0_const", alu_out, 32'h1234_5678);
    run_op(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'd3, 1'b1, 0, "slt");
    chk("slt_const", alu_out, 32'd1);
    run_op(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'd4, 1'b1, 0, "sltu");
    chk("sltu_const", alu_out, 32'd0);
    run_op(32'hC0DE_F00D, 32'd31, 32'd0, 1'b0, 4'd6, 1'b1, 1, "srl31_restart");
    chk("srl31_const", alu_out, 32'd1);
    run_op(32'd5, 32'd7, 32'd0, 1'b0, 4'd0, 1'b0, 2, "start_in_done");
    run_op($urandom, $urandom, $urandom, 1'b0, 4'd12, 1'b1, 0, "op12");

    for (int i = 0; i < 40; i++) begin
      run_op($urandom, $urandom, $urandom, 1'($urandom), 4'($urandom_range(0, 15)),
             1'($urandom), 0, "rand");
    end

    run_op(32'd1, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 0, "pre_rst");
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd10; use_imm = 1'b0; alu_op = 4'd6; wb_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_alu_out", alu_out, 32'd0);
    chk("midrst_save", 32'(save_to_reg), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    #2 reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("postrst_done", 32'(done), 32'd0);
      chk("postrst_save", 32'(save_to_reg), 32'd0);
      chk("postrst_busy", 32'(busy), 32'd0);
    end
    run_op(32'd40, 32'd2, 32'd0, 1'b0, 4'd1, 1'b1, 0, "post_rst_sub");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
